// File: rtl/hdmi_rx_timing_meter.sv
// hdmi_rx_timing_meter
// Measures the raster geometry of a received HDMI video bus (16-bit YCbCr 4:2:2
// with DE/HSYNC/VSYNC), publishes it once per frame, declares lock when the
// geometry repeats, and checks the {8'h80, ramp} loopback test pattern.
//
// Ports (single clock domain, synchronous active-high reset):
//   hdmiin_clk, hdmiin_rst          pixel clock / reset
//   hdmiin_de, hdmiin_hs, hdmiin_vs receiver timing inputs (positive sync)
//   hdmiin_data[15:0]               [15:8] chroma, [7:0] luma
//   chk_en                          ramp checker enable (low clears err_cnt)
//   htotal, hactive                 clocks per line, clocks per DE run
//   vtotal, vactive                 HS rises and DE rises per frame
//   fcnt                            published frame count (wraps)
//   frame_stb                       pulse coincident with each publish
//   locked                          geometry stable for LOCK_FRAMES publishes
//   err_cnt                         ramp-check errors (saturating)
module hdmi_rx_timing_meter #(
    parameter int CW          = 12,
    parameter int LOCK_FRAMES = 2,
    parameter int WD_BITS     = 23
) (
    input  logic          hdmiin_clk,
    input  logic          hdmiin_rst,
    input  logic          hdmiin_de,
    input  logic          hdmiin_hs,
    input  logic          hdmiin_vs,
    input  logic [15:0]   hdmiin_data,
    input  logic          chk_en,
    output logic [CW-1:0] htotal,
    output logic [CW-1:0] hactive,
    output logic [CW-1:0] vtotal,
    output logic [CW-1:0] vactive,
    output logic [15:0]   fcnt,
    output logic          frame_stb,
    output logic          locked,
    output logic [15:0]   err_cnt
);
    localparam int MW = $clog2(LOCK_FRAMES + 1);
    localparam logic [MW-1:0]      MATCH_MAX = MW'(LOCK_FRAMES);
    // One below all-ones: the trip fires on the edge the counter reaches all-ones.
    localparam logic [WD_BITS-1:0] WD_TRIP   = {{(WD_BITS-1){1'b1}}, 1'b0};

    typedef enum logic {IDLE, ARMED} state_t;
    typedef struct packed {
        logic [CW-1:0] ht;
        logic [CW-1:0] ha;
        logic [CW-1:0] vt;
        logic [CW-1:0] va;
    } geom_t;

    (* IOB = "TRUE" *) logic        de_r, hs_r, vs_r;
    (* IOB = "TRUE" *) logic [15:0] data_r;
    logic               de_d, hs_d, vs_d;
    logic [7:0]         luma_d;
    logic               hs_rise, vs_rise, de_rise, de_fall;
    logic [CW-1:0]      pcnt, run, lcnt, acnt;
    logic [CW-1:0]      h_m, ha_m, v_m, va_m;
    geom_t              meas, pub_g;
    logic [MW-1:0]      match, match_nx;
    logic [WD_BITS-1:0] wd;
    logic               wd_trip, pub_arm, pub_req, bad_pix;
    state_t             state_q, state_d;

    assign hs_rise = hs_r & ~hs_d;
    assign vs_rise = vs_r & ~vs_d;
    assign de_rise = de_r & ~de_d;
    assign de_fall = ~de_r & de_d;

    // A VS rise clears the watchdog in the same cycle, so it wins over a trip.
    assign wd_trip = (wd == WD_TRIP) & ~vs_rise;

    assign meas = '{ht: h_m, ha: ha_m, vt: v_m, va: va_m};

    assign htotal  = pub_g.ht;
    assign hactive = pub_g.ha;
    assign vtotal  = pub_g.vt;
    assign vactive = pub_g.va;

    // First pixel of a line (de_d low) only has its chroma byte checked.
    assign bad_pix = chk_en & de_r &
                     ((data_r[15:8] != 8'h80) | (de_d & (data_r[7:0] != luma_d + 8'd1)));

    always_comb begin
        match_nx = '0;
        if (meas == pub_g)
            match_nx = (match == MATCH_MAX) ? match : match + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        pub_arm = 1'b0;
        if (wd_trip)
            state_d = IDLE;
        else if (vs_rise) begin
            if (state_q == IDLE) state_d = ARMED;  // partial frame: arm only
            else                 pub_arm = 1'b1;
        end
    end

    always_ff @(posedge hdmiin_clk) begin
        if (hdmiin_rst) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_ff @(posedge hdmiin_clk) begin
        if (hdmiin_rst) begin
            {de_r, hs_r, vs_r, data_r} <= '0;
            {de_d, hs_d, vs_d, luma_d} <= '0;
            {pcnt, run, lcnt, acnt}    <= '0;
            {h_m, ha_m, v_m, va_m}     <= '0;
            pub_g     <= '0;
            match     <= '0;
            locked    <= 1'b0;
            fcnt      <= '0;
            frame_stb <= 1'b0;
            pub_req   <= 1'b0;
            wd        <= '0;
            err_cnt   <= '0;
        end else begin
            {de_r, hs_r, vs_r, data_r} <= {hdmiin_de, hdmiin_hs, hdmiin_vs, hdmiin_data};
            {de_d, hs_d, vs_d, luma_d} <= {de_r, hs_r, vs_r, data_r[7:0]};

            if (hs_rise) begin
                h_m  <= (pcnt == '1) ? pcnt : pcnt + 1'b1;
                pcnt <= '0;
            end else if (pcnt != '1) begin
                pcnt <= pcnt + 1'b1;
            end

            if (de_fall) begin
                ha_m <= run;
                run  <= '0;
            end else if (de_r && run != '1) begin
                run <= run + 1'b1;
            end

            // A rise coincident with VS is counted in the new frame.
            if (vs_rise) begin
                v_m  <= lcnt;
                va_m <= acnt;
                lcnt <= {{(CW-1){1'b0}}, hs_rise};
                acnt <= {{(CW-1){1'b0}}, de_rise};
            end else begin
                if (hs_rise && lcnt != '1) lcnt <= lcnt + 1'b1;
                if (de_rise && acnt != '1) acnt <= acnt + 1'b1;
            end

            // Publish one cycle after the VS rise so v_m/va_m already hold the frame.
            pub_req   <= pub_arm;
            frame_stb <= pub_req;
            if (pub_req) begin
                pub_g  <= meas;
                fcnt   <= fcnt + 16'd1;
                match  <= match_nx;
                locked <= (match_nx == MATCH_MAX);
            end else if (wd_trip) begin
                match  <= '0;
                locked <= 1'b0;
            end

            if (vs_rise)       wd <= '0;
            else if (wd != '1) wd <= wd + 1'b1;

            if (!chk_en)                        err_cnt <= '0;
            else if (bad_pix && err_cnt != '1) err_cnt <= err_cnt + 16'd1;
        end
    end
endmodule
